// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU control codes, ALU operation classes and FSM state encodings.
package mips_pkg;

  localparam int OPW = 6;
  localparam int STW = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Encodings 13..15 are unused; the FSM recovers from them to S_FETCH.
  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU control decode: the FSM selects add, sub or funct-driven operation;
// unknown funct codes fall back to add without raising any flag.
import mips_pkg::*;

module alu_decoder (
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Control FSM for a multicycle MIPS datapath. Outputs are decoded from the
// state register so an asynchronous reset forces them to idle values at once.
import mips_pkg::*;

module mips_multicycle_controller #(
  parameter int OPW = mips_pkg::OPW,
  parameter int STW = mips_pkg::STW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pcen,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [2:0]     alucontrol,
  output logic           illegal_op,
  output logic [STW-1:0] state_dbg
);

  state_t state;
  state_t state_next;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    case (state)
      S_RESET: state_next = S_FETCH;
      // PC and IR only update on the cycle memory actually returns the word.
      S_FETCH: begin
        alusrcb    = 2'b01;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      // Strobe stays asserted across stall cycles until memory accepts.
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign pcen      = pcwrite | (branch & zero);
  assign state_dbg = STW'(state);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct[5:0]),
    .alucontrol (alucontrol)
  );

endmodule
